alu_operand_loader: RTL and testbench

Sequential front end for the 3-bit signed switch ALU on the lab board. It debounces a load button and steps through a small state machine that captures operand `a`, then operand `b` and the operation select, from the switches. It then issues the operation to the ALU with a valid/ready handshake and registers the returned result and overflow flag for the LED/7-segment display. It sits directly upstream of the ALU/display stage and replaces its direct wiring from `SWI`.

---
 rtl/alu_operand_loader_if.sv | 23 ++
 rtl/alu_operand_loader.sv | 151 +++++++++++++++
 tb/tb_alu_operand_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_loader_if.sv
// Operand/handshake bundle between the switch loader (master) and the ALU (slave).
// The loader presents operands with op_valid; the ALU answers in the op_ready cycle.
interface alu_operand_loader_if #(
  parameter int NBITS_OP = 3
);
  logic [NBITS_OP-1:0] a_out;
  logic [NBITS_OP-1:0] b_out;
  logic [1:0]          f_out;
  logic                op_valid;
  logic                op_ready;
  logic [NBITS_OP-1:0] result_in;
  logic                ovf_in;

  modport master (
    output a_out, b_out, f_out, op_valid,
    input  op_ready, result_in, ovf_in
  );

  modport slave (
    input  a_out, b_out, f_out, op_valid,
    output op_ready, result_in, ovf_in
  );
endinterface

// File: rtl/alu_operand_loader.sv
// Debounced-button operand loader for the switch ALU: captures a, then b/op,
// issues them with valid/ready and holds the returned result for display.
module alu_operand_loader #(
  parameter int DB_CYCLES = 2,
  parameter int NBITS_OP  = 3
) (
  input  logic                 clk_2,
  input  logic                 rst_n,
  input  logic [NBITS_OP-1:0]  data_in,
  input  logic [1:0]           sel_in,
  input  logic                 load,
  input  logic                 clear,
  alu_operand_loader_if.master alu,
  output logic [NBITS_OP-1:0]  result_q,
  output logic                 ovf_q,
  output logic                 done,
  output logic [1:0]           state_o,
  output logic [3:0]           op_count
);

  // LOAD_A: wait a | LOAD_B: wait b,op | ISSUE: op_valid to ALU | DONE: hold result
  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    ISSUE  = 2'b10,
    DONE   = 2'b11
  } state_t;

  localparam logic [3:0] DB_TC = 4'(DB_CYCLES);

  logic [1:0] sync_q;
  logic [1:0] fill_q;
  logic       load_s;
  logic       armed_q, armed_d;
  logic       deb_q, deb_d;
  logic       deb_dly_q;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;
  logic       press;

  state_t              state_q, state_d;
  logic [NBITS_OP-1:0] a_q, a_d;
  logic [NBITS_OP-1:0] b_q, b_d;
  logic [1:0]          f_q, f_d;
  logic [NBITS_OP-1:0] result_d;
  logic                ovf_d;
  logic [3:0]          op_count_q, op_count_d;

  assign load_s  = sync_q[1];
  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    cnt_d = 4'd0;
    deb_d = deb_q;
    if (load_s != deb_q) begin
      if (cnt_inc == DB_TC) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // A button held through reset must be seen released once before it can press;
  // fill_q marks when the synchronizer holds real post-reset samples.
  assign armed_d = armed_q | (fill_q[1] & ~load_s);
  assign press   = deb_q & ~deb_dly_q & armed_q;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    f_d        = f_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    op_count_d = op_count_q;
    if (clear) begin
      state_d = LOAD_A;
    end else begin
      unique case (state_q)
        LOAD_A: begin
          if (press) begin
            a_d     = data_in;
            state_d = LOAD_B;
          end
        end
        LOAD_B: begin
          if (press) begin
            b_d     = data_in;
            f_d     = sel_in;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (alu.op_ready) begin
            result_d   = alu.result_in;
            ovf_d      = alu.ovf_in;
            op_count_d = op_count_q + 4'd1;
            state_d    = DONE;
          end
        end
        DONE: begin
          if (press) begin
            state_d = LOAD_A;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_2) begin
    if (!rst_n) begin
      sync_q     <= 2'b00;
      fill_q     <= 2'b00;
      armed_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_dly_q  <= 1'b0;
      cnt_q      <= 4'd0;
      state_q    <= LOAD_A;
      a_q        <= '0;
      b_q        <= '0;
      f_q        <= 2'b00;
      result_q   <= '0;
      ovf_q      <= 1'b0;
      op_count_q <= 4'd0;
    end else begin
      sync_q     <= {sync_q[0], load};
      fill_q     <= {fill_q[0], 1'b1};
      armed_q    <= armed_d;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_q;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      f_q        <= f_d;
      result_q   <= result_d;
      ovf_q      <= ovf_d;
      op_count_q <= op_count_d;
    end
  end

  assign alu.a_out    = a_q;
  assign alu.b_out    = b_q;
  assign alu.f_out    = f_q;
  assign alu.op_valid = (state_q == ISSUE);
  assign done         = (state_q == DONE);
  assign state_o      = state_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_alu_operand_loader;

  localparam int DB = 2;
  localparam int NB = 3;
  localparam int S_A = 0, S_B = 1, S_I = 2, S_D = 3;

  logic          clk_2 = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] data_in = '0;
  logic [1:0]    sel_in = 2'b00;
  logic          load = 1'b0;
  logic          clear = 1'b0;
  logic [NB-1:0] result_q;
  logic          ovf_q;
  logic          done;
  logic [1:0]    state_o;
  logic [3:0]    op_count;

  alu_operand_loader_if #(.NBITS_OP(NB)) alu_if ();

  alu_operand_loader #(.DB_CYCLES(DB), .NBITS_OP(NB)) dut (
    .clk_2    (clk_2),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .sel_in   (sel_in),
    .load     (load),
    .clear    (clear),
    .alu      (alu_if),
    .result_q (result_q),
    .ovf_q    (ovf_q),
    .done     (done),
    .state_o  (state_o),
    .op_count (op_count)
  );

  always #5 clk_2 = ~clk_2;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: debounced level follows the synchronized button once it
  // has disagreed for DB consecutive samples; FSM rules taken from the spec.
  int            n_edge;
  bit            q_samp[$];
  bit            m_deb, m_deb_dly, m_armed;
  int            m_state;
  logic [NB-1:0] m_a, m_b, m_res;
  logic [1:0]    m_f;
  logic          m_ovf;
  int            m_cnt;

  function automatic bit ls_at(input int e);
    return (e >= 3) ? q_samp[e-3] : 1'b0;
  endfunction

  always @(posedge clk_2) begin : model
    bit press, win;
    if (!rst_n) begin
      n_edge = 0; q_samp.delete();
      m_deb = 0; m_deb_dly = 0; m_armed = 0;
      m_state = S_A; m_a = '0; m_b = '0; m_f = '0; m_res = '0; m_ovf = 0; m_cnt = 0;
    end else begin
      n_edge++;
      q_samp.push_back(load);
      press = m_deb && !m_deb_dly && m_armed;
      win = 1'b1;
      for (int e = n_edge - DB + 1; e <= n_edge; e++)
        if (e < 1 || ls_at(e) == m_deb) win = 1'b0;
      if (n_edge >= 3 && q_samp[n_edge-3] == 1'b0) m_armed = 1'b1;
      m_deb_dly = m_deb;
      if (win) m_deb = !m_deb;
      if (clear) m_state = S_A;
      else case (m_state)
        S_A: if (press) begin m_a = data_in; m_state = S_B; end
        S_B: if (press) begin m_b = data_in; m_f = sel_in; m_state = S_I; end
        S_I: if (alu_if.op_ready) begin
               m_res = alu_if.result_in; m_ovf = alu_if.ovf_in;
               m_cnt = (m_cnt + 1) % 16; m_state = S_D;
             end
        default: if (press) m_state = S_A;
      endcase
    end
  end

  always @(negedge clk_2) begin
    if (chk_on) begin
      chk("state_o",  state_o,         m_state);
      chk("a_out",    alu_if.a_out,    m_a);
      chk("b_out",    alu_if.b_out,    m_b);
      chk("f_out",    alu_if.f_out,    m_f);
      chk("op_valid", alu_if.op_valid, (m_state == S_I));
      chk("done",     done,            (m_state == S_D));
      chk("result_q", result_q,        m_res);
      chk("ovf_q",    ovf_q,           m_ovf);
      chk("op_count", op_count,        m_cnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  task automatic press_btn();
    load = 1'b1; tick(DB + 4);
    load = 1'b0; tick(DB + 4);
  endtask

  task automatic wait_state(input int s, input int budget);
    int k = 0;
    while (state_o != 2'(s) && k < budget) begin tick(1); k++; end
    if (k >= budget) chk("wait_state_timeout", state_o, s);
  endtask

  task automatic handshake(input logic [NB-1:0] r, input logic o);
    alu_if.op_ready = 1'b1; alu_if.result_in = r; alu_if.ovf_in = o;
    tick(1);
    alu_if.op_ready = 1'b0;
  endtask

  task automatic full_op(input int delay);
    data_in = NB'($urandom); press_btn();
    data_in = NB'($urandom); sel_in = 2'($urandom); press_btn();
    wait_state(S_I, 50);
    tick(delay);
    handshake(NB'($urandom), 1'($urandom));
    wait_state(S_D, 5);
    press_btn();
  endtask

  initial begin
    alu_if.op_ready = 1'b0; alu_if.result_in = '0; alu_if.ovf_in = 1'b0;

    // reset with button held: all zero, and no press after release
    load = 1'b1; rst_n = 1'b0; tick(3);
    chk_on = 1'b1;
    chk("rst_state", state_o, 0);
    chk("rst_a", alu_if.a_out, 0);
    chk("rst_valid", alu_if.op_valid, 0);
    chk("rst_count", op_count, 0);
    rst_n = 1'b1; tick(10);
    chk("held_no_press", state_o, 0);
    load = 1'b0; tick(DB + 4);

    // latency: first sampled at edge k, capture at edge k+4
    data_in = 3'b011;
    load = 1'b1; tick(4);
    chk("lat_before", state_o, 0);
    tick(1);
    chk("lat_capture", state_o, 1);
    chk("lat_a", alu_if.a_out, 3'b011);
    tick(DB + 1); load = 1'b0; tick(DB + 4);

    data_in = 3'b110; sel_in = 2'b00; press_btn();
    chk("issue_valid", alu_if.op_valid, 1);
    handshake(3'b001, 1'b0);
    chk("op_a", alu_if.a_out, 3'b011);
    chk("op_b", alu_if.b_out, 3'b110);
    chk("op_res", result_q, 3'b001);
    chk("op_done", done, 1);
    chk("op_count1", op_count, 1);

    // press in DONE returns without capture; short bounces filtered
    data_in = 3'b111; press_btn();
    chk("done_ret", state_o, 0);
    chk("done_nocap", alu_if.a_out, 3'b011);
    for (int i = 0; i < 5; i++) begin load = 1'b1; tick(DB - 1); load = 1'b0; tick(4); end
    chk("bounce_state", state_o, 0);

    // backpressure with presses and switch activity
    data_in = 3'b001; press_btn();
    data_in = 3'b010; sel_in = 2'b10; press_btn();
    for (int i = 0; i < 12; i++) begin
      data_in = NB'($urandom); sel_in = 2'($urandom); load = (i < 6); tick(1);
    end
    load = 1'b0; tick(4);
    chk("bp_state", state_o, 2);
    chk("bp_valid", alu_if.op_valid, 1);
    chk("bp_a", alu_if.a_out, 3'b001);
    chk("bp_b", alu_if.b_out, 3'b010);
    chk("bp_f", alu_if.f_out, 2'b10);
    handshake(3'b100, 1'b1);
    chk("bp_ovf", ovf_q, 1);
    chk("bp_res", result_q, 3'b100);

    // clear wins over a same-cycle handshake
    press_btn(); press_btn(); press_btn();
    wait_state(S_I, 20);
    clear = 1'b1; alu_if.op_ready = 1'b1; alu_if.result_in = 3'b111;
    tick(1);
    clear = 1'b0; alu_if.op_ready = 1'b0;
    chk("clr_state", state_o, 0);
    chk("clr_count", op_count, 2);
    chk("clr_res", result_q, 3'b100);
    chk("clr_done", done, 0);

    // 14 more operations take the count from 2 through the wrap to 0
    for (int i = 0; i < 14; i++) full_op($urandom_range(0, 4));
    chk("wrap_count", op_count, 0);

    // random phase: bouncing button, switches, ready, occasional clear/reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) load = ~load;
      data_in = NB'($urandom); sel_in = 2'($urandom);
      alu_if.op_ready  = ($urandom_range(0, 3) == 0);
      alu_if.result_in = NB'($urandom); alu_if.ovf_in = 1'($urandom);
      clear = ($urandom_range(0, 60) == 0);
      rst_n = ($urandom_range(0, 400) != 0);
      tick(1);
    end
    rst_n = 1'b1; clear = 1'b0; alu_if.op_ready = 1'b0; load = 1'b0;
    tick(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
